// File: rtl/spec_buf_pkg.sv
// spec_buf_pkg: shared state encodings and frame-length helper for the spectral frame buffer.
package spec_buf_pkg;

  typedef enum logic {W_IDLE, W_FILL} wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;

  function automatic int frame_len(input int lg);
    return 1 << lg;
  endfunction

endpackage

// File: rtl/spec_buf_dpram.sv
// spec_buf_dpram: simple dual-port RAM with a registered read port that holds its last value when idle.
module spec_buf_dpram #(
  parameter int DW = 42,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];

endmodule

// File: rtl/spec_frame_buf.sv
// spec_frame_buf: ping-pong frame buffer replaying N-bin spectral frames back to back.
// Define SPECBUF_BITREV_EN to replay each frame in bit-reversed bin order.
module spec_frame_buf import spec_buf_pkg::*; #(
  parameter int WIDTH   = 21,
  parameter int LGWIDTH = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_ce,
  input  logic [2*WIDTH-1:0]   i_sample,
  input  logic                 i_sync,
  output logic                 o_ce,
  output logic [2*WIDTH-1:0]   o_sample,
  output logic                 o_sync,
  output logic                 o_overflow,
  output logic                 o_sync_err
);

  localparam int N = frame_len(LGWIDTH);
  localparam logic [LGWIDTH-1:0] LAST = LGWIDTH'(N - 1);

  wr_state_t          w_state, w_next;
  rd_state_t          r_state, r_next;
  logic               w_bank, w_bank_next, r_bank, r_bank_next;
  logic [LGWIDTH-1:0] w_addr, w_addr_next, r_cnt, r_cnt_next, wr_addr, rd_addr;
  logic [1:0]         full, full_next;
  logic               sync_err_next, we, re, done, release_b, busy, accept;

  assign we        = i_ce && (i_sync || w_state == W_FILL);
  assign wr_addr   = i_sync ? '0 : w_addr;
  assign done      = i_ce && !i_sync && w_state == W_FILL && w_addr == LAST;
  assign re        = r_state == R_DRAIN;
  assign release_b = re && r_cnt == LAST;
  // A bank released in the same cycle is free for the completing frame.
  assign busy      = full[~w_bank] && !(release_b && r_bank == ~w_bank);
  assign accept    = done && !busy;

  always_comb begin
    w_next        = w_state;
    w_addr_next   = w_addr;
    w_bank_next   = w_bank;
    sync_err_next = o_sync_err;
    if (i_ce && i_sync) begin
      w_next        = W_FILL;
      w_addr_next   = LGWIDTH'(1);
      sync_err_next = o_sync_err || w_state == W_FILL;
    end else if (i_ce && w_state == W_FILL) begin
      w_addr_next = w_addr + LGWIDTH'(1);
      w_next      = done ? W_IDLE : W_FILL;
      w_bank_next = w_bank ^ accept;
    end
  end

  always_comb begin
    full_next = full;
    if (release_b) full_next[r_bank] = 1'b0;
    if (accept) full_next[w_bank] = 1'b1;
  end

  // Banks are filled and drained alternately, so the reader just follows r_bank.
  always_comb begin
    r_next      = r_state;
    r_bank_next = r_bank;
    r_cnt_next  = r_cnt;
    if (r_state == R_IDLE) begin
      r_next = full_next[r_bank] ? R_DRAIN : R_IDLE;
    end else begin
      r_cnt_next = r_cnt + LGWIDTH'(1);
      if (release_b) begin
        r_bank_next = ~r_bank;
        r_next      = full_next[~r_bank] ? R_DRAIN : R_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      w_state    <= W_IDLE;
      r_state    <= R_IDLE;
      w_bank     <= 1'b0;
      r_bank     <= 1'b0;
      w_addr     <= '0;
      r_cnt      <= '0;
      full       <= '0;
      o_ce       <= 1'b0;
      o_sync     <= 1'b0;
      o_overflow <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      w_state    <= w_next;
      r_state    <= r_next;
      w_bank     <= w_bank_next;
      r_bank     <= r_bank_next;
      w_addr     <= w_addr_next;
      r_cnt      <= r_cnt_next;
      full       <= full_next;
      o_ce       <= re;
      o_sync     <= re && r_cnt == '0;
      o_overflow <= done && busy;
      o_sync_err <= sync_err_next;
    end

`ifdef SPECBUF_BITREV_EN
  for (genvar i = 0; i < LGWIDTH; i++) begin : g_rev
    assign rd_addr[i] = r_cnt[LGWIDTH-1-i];
  end
`else
  assign rd_addr = r_cnt;
`endif

  spec_buf_dpram #(.DW(2*WIDTH), .AW(LGWIDTH+1)) u_ram (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .we    (we),
    .waddr ({w_bank, wr_addr}),
    .wdata (i_sample),
    .re    (re),
    .raddr ({r_bank, rd_addr}),
    .rdata (o_sample)
  );

endmodule

// File: tb/tb_spec_frame_buf.sv
// tb_spec_frame_buf: directed self-checking bench for spec_frame_buf with N=8.
module tb_spec_frame_buf;

  localparam int W = 21, LG = 3, N = 8, DW = 2*W;

  typedef struct {
    logic          ce;
    logic          sync;
    logic [DW-1:0] sample;
    logic          exp_ce;
    logic          exp_sync;
    logic [DW-1:0] exp_sample;
  } vec_t;

  logic          i_clk = 0, i_reset_n = 0, i_ce = 0, i_sync = 0;
  logic [DW-1:0] i_sample = '0;
  logic          o_ce, o_sync, o_overflow, o_sync_err;
  logic [DW-1:0] o_sample;
  int            checks = 0, failures = 0, cyc = 0, ovf = 0;
  logic [DW-1:0] q_data[$], exp_q[$];
  logic          q_sync[$];
  int            q_cyc[$];
  vec_t          vecs[20];

  always #5 i_clk = ~i_clk;

  spec_frame_buf #(.WIDTH(W), .LGWIDTH(LG)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_ce       (i_ce),
    .i_sample   (i_sample),
    .i_sync     (i_sync),
    .o_ce       (o_ce),
    .o_sample   (o_sample),
    .o_sync     (o_sync),
    .o_overflow (o_overflow),
    .o_sync_err (o_sync_err)
  );

  always @(posedge i_clk) begin
    #1;
    cyc++;
    if (o_ce) begin
      q_data.push_back(o_sample);
      q_sync.push_back(o_sync);
      q_cyc.push_back(cyc);
    end
    if (o_overflow) ovf++;
  end

  function automatic int ord(input int k);
`ifdef SPECBUF_BITREV_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic sync, input logic [DW-1:0] s);
    @(negedge i_clk);
    i_ce = ce;
    i_sync = sync;
    i_sample = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic send(input int base, input bit half);
    for (int i = 0; i < N; i++) begin
      drive(1'b1, i == 0, DW'(base + i));
      if (half) drive(1'b0, 1'b0, '0);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic push_exp(input int base);
    for (int k = 0; k < N; k++) exp_q.push_back(DW'(base + ord(k)));
  endtask

  task automatic clear_q();
    q_data.delete();
    q_sync.delete();
    q_cyc.delete();
  endtask

  task automatic expect_frames(input string name, input int n, input bit span_all);
    for (int c = 0; c < 400 && q_data.size() < n; c++) @(posedge i_clk);
    repeat (6) @(posedge i_clk);
    #2;
    chk({name, " count"}, 64'(q_data.size()), 64'(n));
    for (int k = 0; k < n && k < q_data.size(); k++) begin
      chk($sformatf("%s data[%0d]", name, k), 64'(q_data[k]), 64'(exp_q[k]));
      chk($sformatf("%s sync[%0d]", name, k), 64'(q_sync[k]), 64'(k % N == 0));
      if (k > 0 && (span_all || k % N != 0))
        chk($sformatf("%s gap[%0d]", name, k), 64'(q_cyc[k] - q_cyc[k-1]), 64'd1);
    end
    clear_q();
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 20; i++) begin
      vecs[i].ce         = i < N;
      vecs[i].sync       = i == 0;
      vecs[i].sample     = i < N ? DW'(i + 1) : '0;
      vecs[i].exp_ce     = i >= 8 && i <= 15;
      vecs[i].exp_sync   = i == 8;
      vecs[i].exp_sample = i < 8 ? '0 : i <= 15 ? DW'(ord(i - 8) + 1) : DW'(ord(7) + 1);
    end

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst o_ce", 64'(o_ce), 0);
    chk("rst o_sync", 64'(o_sync), 0);
    chk("rst o_sample", 64'(o_sample), 0);
    chk("rst o_overflow", 64'(o_overflow), 0);
    chk("rst o_sync_err", 64'(o_sync_err), 0);
    @(negedge i_clk);
    i_reset_n = 1;

    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      i_ce = vecs[i].ce;
      i_sync = vecs[i].sync;
      i_sample = vecs[i].sample;
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d o_ce", i), 64'(o_ce), 64'(vecs[i].exp_ce));
      chk($sformatf("vec%0d o_sync", i), 64'(o_sync), 64'(vecs[i].exp_sync));
      chk($sformatf("vec%0d o_sample", i), 64'(o_sample), 64'(vecs[i].exp_sample));
    end
    idle(2);
    clear_q();

    ovf = 0;
    send(16'h101, 1'b0);
    clear_q();
    exp_q.delete();
    idle(20);
    clear_q();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) drive(1'b1, i == 0, DW'(16'h200 + 16 * f + i));
    drive(1'b0, 1'b0, '0);
    for (int f = 0; f < 3; f++) push_exp(16'h200 + 16 * f);
    expect_frames("b2b", 3 * N, 1'b1);
    chk("b2b overflow", 64'(ovf), 0);

    chk("pre sync_err", 64'(o_sync_err), 0);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, DW'(16'h21 + i));
    send(16'h31, 1'b0);
    push_exp(16'h31);
    expect_frames("restart", N, 1'b0);
    chk("sync_err set", 64'(o_sync_err), 1);

    send(16'h71, 1'b1);
    push_exp(16'h71);
    expect_frames("half_duty", N, 1'b0);
    chk("sync_err sticky", 64'(o_sync_err), 1);

`ifdef SPECBUF_BITREV_EN
    begin
      int br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      send(0, 1'b0);
      for (int k = 0; k < N; k++) exp_q.push_back(DW'(br[k]));
      expect_frames("bitrev", N, 1'b0);
    end
`endif

    send(16'h41, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, DW'(16'h51 + i));
    @(negedge i_clk);
    i_reset_n = 0;
    i_ce = 0;
    i_sync = 0;
    #1;
    chk("midrst o_ce", 64'(o_ce), 0);
    chk("midrst o_sample", 64'(o_sample), 0);
    chk("midrst o_sync_err", 64'(o_sync_err), 0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("midrst hold o_ce", 64'(o_ce), 0);
    chk("midrst hold o_sync", 64'(o_sync), 0);
    chk("midrst hold o_overflow", 64'(o_overflow), 0);
    chk("midrst hold o_sample", 64'(o_sample), 0);
    clear_q();
    @(negedge i_clk);
    i_reset_n = 1;
    idle(2);
    send(16'h61, 1'b0);
    push_exp(16'h61);
    expect_frames("post_rst", N, 1'b0);
    chk("final sync_err", 64'(o_sync_err), 0);
    chk("final overflow", 64'(ovf), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
